chrono_core: RTL

//  Parametrised stopwatch/countdown-timer core: N BCD digits, debounced keys, lap freeze, expiry.

---
 rtl/chrono_pkg.sv | 6 +
 rtl/chrono_key_debounce.sv | 37 +++
 rtl/chrono_core.sv | 131 +++++++++++++
 3 files changed

// File: rtl/chrono_pkg.sv
// chrono_pkg: shared FSM state type and BCD digit limits for the chrono core.
package chrono_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;
    localparam logic [3:0] BCD_MAX9 = 4'd9;
    localparam logic [3:0] BCD_MAX6 = 4'd5;
endpackage

// File: rtl/chrono_key_debounce.sv
// key_debounce: synchronises an active-low raw key, debounces it and emits one pulse per accepted press.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    logic sync1_q, sync2_q, stable_q, stable_d, press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        stable_d = stable_q;
        press_d  = 1'b0;
        cnt_d    = (sync2_q != stable_q) ? cnt_q + 1'b1 : '0;
        if (sync2_q != stable_q && cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
            stable_d = sync2_q;
            press_d  = !sync2_q;
            cnt_d    = '0;
        end
    end
    // Idle level of the key is high, so reset to "released" to avoid a spurious press.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            {sync1_q, sync2_q, stable_q} <= 3'b111;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            {sync1_q, sync2_q} <= {key_ni, sync1_q};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end
    assign press_o = press_q;
endmodule

// File: rtl/chrono_core.sv
// chrono_core: N-digit BCD stopwatch/countdown timer with run/pause/done FSM, lap hold and expiry.
module chrono_core
    import chrono_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_HZ = 50_000_000,
    parameter int TICK_HZ = 100,
    parameter logic [NUM_DIGITS-1:0] MOD6_MASK = NUM_DIGITS'(4'b1000),
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic key_ss_n,
    input  logic key_lap_n,
    input  logic mode_timer,
    input  logic preset_load,
    input  logic [4*NUM_DIGITS-1:0] preset_bcd,
    output logic [4*NUM_DIGITS-1:0] digits_bcd,
    output logic running,
    output logic lap_active,
    output logic expired,
    output logic overflow,
    output logic mode_led
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW = $clog2(DIV);
    localparam int W = 4 * NUM_DIGITS;
    state_e state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [W-1:0] cnt_q, cnt_d, lap_val_q, lap_val_d, inc_v, dec_v, clamp_v;
    logic lap_q, lap_d, ovf_q, ovf_d, mode_q, mode_d, expired_q, expired_d;
    logic ss_p, lap_p, tick, cfg, load, all_zero;
    logic [NUM_DIGITS-1:0] is_max, is_zero, cin, bin;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ss (
        .clk_i(CLOCK_50), .rst_ni(RESET_N), .key_ni(key_ss_n), .press_o(ss_p));
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_lap (
        .clk_i(CLOCK_50), .rst_ni(RESET_N), .key_ni(key_lap_n), .press_o(lap_p));

    // Carry/borrow into a digit is the AND of the lower digits' max/zero flags, so no ripple loop.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        localparam logic [3:0] MX = MOD6_MASK[i] ? BCD_MAX6 : BCD_MAX9;
        logic [3:0] d, p;
        assign d = cnt_q[4*i +: 4];
        assign p = preset_bcd[4*i +: 4];
        assign is_max[i]  = d == MX;
        assign is_zero[i] = d == 4'd0;
        if (i == 0) begin : g_lsd
            assign cin[i] = 1'b1;
            assign bin[i] = 1'b1;
        end else begin : g_up
            assign cin[i] = &is_max[i-1:0];
            assign bin[i] = &is_zero[i-1:0];
        end
        assign inc_v[4*i +: 4]   = cin[i] ? (is_max[i] ? 4'd0 : d + 4'd1) : d;
        assign dec_v[4*i +: 4]   = bin[i] ? (is_zero[i] ? MX : d - 4'd1) : d;
        assign clamp_v[4*i +: 4] = p > MX ? MX : p;
    end

    assign cfg      = state_q == IDLE || state_q == DONE;
    assign load     = cfg && preset_load;
    assign tick     = state_q == RUN && pre_q == PW'(DIV - 1);
    assign all_zero = &is_zero;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        pre_d     = pre_q;
        lap_d     = lap_q;
        lap_val_d = lap_val_q;
        mode_d    = cfg ? mode_timer : mode_q;
        if (state_q == RUN) pre_d = tick ? '0 : pre_q + 1'b1;
        if (tick) begin
            cnt_d = mode_q ? (all_zero ? cnt_q : dec_v) : inc_v;
            if (!mode_q && &is_max) ovf_d = 1'b1;
        end
        if (load) cnt_d = clamp_v;
        case (state_q)
            IDLE: if (ss_p && !(mode_q && all_zero)) begin
                state_d = RUN;
                pre_d   = '0;
            end
            RUN: if (ss_p) state_d = PAUSE;
                 else if (tick && mode_q && cnt_d == '0) state_d = DONE;
            PAUSE: if (ss_p) state_d = RUN;
                   else if (lap_p) begin
                       state_d = IDLE;
                       cnt_d   = '0;
                       ovf_d   = 1'b0;
                   end
            DONE: if (ss_p || lap_p || preset_load) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q == RUN && lap_p && !ss_p) begin
            lap_d = !lap_q;
            if (!lap_q) lap_val_d = cnt_q;
        end
        if (state_d != RUN) lap_d = 1'b0;
        expired_d = state_q == RUN && state_d == DONE;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            cnt_q     <= '0;
            lap_val_q <= '0;
            lap_q     <= 1'b0;
            ovf_q     <= 1'b0;
            mode_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            lap_val_q <= lap_val_d;
            lap_q     <= lap_d;
            ovf_q     <= ovf_d;
            mode_q    <= mode_d;
            expired_q <= expired_d;
        end
    end

    assign digits_bcd = lap_q ? lap_val_q : cnt_q;
    assign running    = state_q == RUN;
    assign lap_active = lap_q;
    assign expired    = expired_q;
    assign overflow   = ovf_q;
    assign mode_led   = mode_q;
endmodule
